// File: rtl/rf_pkg.sv
// Shared definitions for the register_file_sb slice.
//   ZERO_REG : index of the hard-wired zero register
//   sat_inc  : increment that holds at the all-ones value of a w-bit counter
package rf_pkg;

  localparam int ZERO_REG = 0;

  // Operates on a 32-bit container; callers zero-extend a w-bit counter and
  // truncate the result back to w bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending scoreboard for multi-cycle producers.
//   Clk, Reset          : clock and synchronous active-high reset
//   set_en / set_idx    : issue of a producer that will write set_idx
//   clr_en / clr_idx    : writeback to clr_idx (clears its pending bit)
//   rd_idx1 / rd_idx2   : read-port addresses to look up
//   busy1 / busy2       : pending state seen by each read port
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int AW     = $clog2(DEPTH),
  parameter bit BYPASS = 1'b1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic [AW-1:0] rd_idx1,
  input  logic [AW-1:0] rd_idx2,
  output logic          busy1,
  output logic          busy2
);

  logic [DEPTH-1:0] pending;
  logic             set_ok;
  logic             clr_ok;

  // Register 0 can never be marked or cleared.
  assign set_ok = set_en && (set_idx != AW'(ZERO_REG));
  assign clr_ok = clr_en && (clr_idx != AW'(ZERO_REG));

  // The set is applied after the clear so a same-cycle issue to the register
  // being written leaves the new producer outstanding.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pending <= '0;
    end else begin
      if (clr_ok) pending[clr_idx] <= 1'b0;
      if (set_ok) pending[set_idx] <= 1'b1;
    end
  end

  // A same-cycle write supplies the data through the bypass, so the reader
  // need not stall on it.
  always_comb begin
    busy1 = pending[rd_idx1];
    busy2 = pending[rd_idx2];
    if (BYPASS && clr_ok && (clr_idx == rd_idx1)) busy1 = 1'b0;
    if (BYPASS && clr_ok && (clr_idx == rd_idx2)) busy2 = 1'b0;
  end

endmodule

// File: rtl/register_file_sb.sv
// Parametrised two-read / one-write register file with pending scoreboard.
//   Clk, Reset                 : clock, synchronous active-high reset
//   ReadRegister1/2            : read addresses
//   ReadData1/2, Busy1/2       : read data and pending state (combinational)
//   WriteRegister, WriteData,
//   RegWrite                   : writeback port
//   IssueEnable, IssueRegister : marks a register pending
//   DebugData                  : stored value of register DEBUG_REG
//   WriteCount                 : saturating count of accepted writes
module register_file_sb
  import rf_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 32,
  parameter int AW        = $clog2(DEPTH),
  parameter bit BYPASS    = 1'b1,
  parameter int DEBUG_REG = 16,
  parameter int CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [AW-1:0]    ReadRegister1,
  input  logic [AW-1:0]    ReadRegister2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2,
  output logic             Busy1,
  output logic             Busy2,
  input  logic [AW-1:0]    WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  input  logic             RegWrite,
  input  logic             IssueEnable,
  input  logic [AW-1:0]    IssueRegister,
  output logic [WIDTH-1:0] DebugData,
  output logic [CNT_W-1:0] WriteCount
);

  localparam logic [AW-1:0] DBG_IDX = AW'(DEBUG_REG);

  logic [WIDTH-1:0] regs [DEPTH];
  logic             wr_ok;

  assign wr_ok = RegWrite && (WriteRegister != AW'(ZERO_REG));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      WriteCount <= '0;
    end else if (wr_ok) begin
      regs[WriteRegister] <= WriteData;
      WriteCount          <= CNT_W'(sat_inc(32'(WriteCount), CNT_W));
    end
  end

  // Address 0 is forced to zero rather than relying on the array contents.
  always_comb begin
    ReadData1 = (ReadRegister1 == AW'(ZERO_REG)) ? '0 : regs[ReadRegister1];
    ReadData2 = (ReadRegister2 == AW'(ZERO_REG)) ? '0 : regs[ReadRegister2];
    if (BYPASS && wr_ok && (WriteRegister == ReadRegister1)) ReadData1 = WriteData;
    if (BYPASS && wr_ok && (WriteRegister == ReadRegister2)) ReadData2 = WriteData;
  end

  assign DebugData = (DEBUG_REG == ZERO_REG) ? '0 : regs[DBG_IDX];

  rf_scoreboard #(
    .DEPTH  (DEPTH),
    .AW     (AW),
    .BYPASS (BYPASS)
  ) u_sb (
    .Clk     (Clk),
    .Reset   (Reset),
    .set_en  (IssueEnable),
    .set_idx (IssueRegister),
    .clr_en  (RegWrite),
    .clr_idx (WriteRegister),
    .rd_idx1 (ReadRegister1),
    .rd_idx2 (ReadRegister2),
    .busy1   (Busy1),
    .busy2   (Busy2)
  );

endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench for register_file_sb. Three builds share one stimulus:
//   A: BYPASS=1, CNT_W=16   B: BYPASS=0   C: CNT_W=3
module tb_register_file_sb;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [4:0]  RR1, RR2, WR, IR;
  logic [31:0] WD;
  logic        RegWrite, IssueEnable;

  logic [31:0] rd1_a, rd2_a, dbg_a, rd1_b, rd2_b, dbg_b, rd1_c, rd2_c, dbg_c;
  logic        b1_a, b2_a, b1_b, b2_b, b1_c, b2_c;
  logic [15:0] cnt_a, cnt_b;
  logic [2:0]  cnt_c;

  always #5 Clk = ~Clk;

  register_file_sb #(.BYPASS(1'b1), .CNT_W(16)) dut_a (
    .Clk(Clk), .Reset(Reset), .ReadRegister1(RR1), .ReadRegister2(RR2),
    .ReadData1(rd1_a), .ReadData2(rd2_a), .Busy1(b1_a), .Busy2(b2_a),
    .WriteRegister(WR), .WriteData(WD), .RegWrite(RegWrite),
    .IssueEnable(IssueEnable), .IssueRegister(IR), .DebugData(dbg_a), .WriteCount(cnt_a));

  register_file_sb #(.BYPASS(1'b0), .CNT_W(16)) dut_b (
    .Clk(Clk), .Reset(Reset), .ReadRegister1(RR1), .ReadRegister2(RR2),
    .ReadData1(rd1_b), .ReadData2(rd2_b), .Busy1(b1_b), .Busy2(b2_b),
    .WriteRegister(WR), .WriteData(WD), .RegWrite(RegWrite),
    .IssueEnable(IssueEnable), .IssueRegister(IR), .DebugData(dbg_b), .WriteCount(cnt_b));

  register_file_sb #(.BYPASS(1'b1), .CNT_W(3)) dut_c (
    .Clk(Clk), .Reset(Reset), .ReadRegister1(RR1), .ReadRegister2(RR2),
    .ReadData1(rd1_c), .ReadData2(rd2_c), .Busy1(b1_c), .Busy2(b2_c),
    .WriteRegister(WR), .WriteData(WD), .RegWrite(RegWrite),
    .IssueEnable(IssueEnable), .IssueRegister(IR), .DebugData(dbg_c), .WriteCount(cnt_c));

  typedef enum int {
    S_RD1A, S_RD2A, S_B1A, S_B2A, S_DBGA, S_CNTA,
    S_RD1B, S_RD2B, S_CNTC, S_RD1C, S_B1C
  } sel_e;

  typedef struct {
    string       name;
    sel_e        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [31:0] actual(input sel_e s);
    case (s)
      S_RD1A: return rd1_a;
      S_RD2A: return rd2_a;
      S_B1A:  return 32'(b1_a);
      S_B2A:  return 32'(b2_a);
      S_DBGA: return dbg_a;
      S_CNTA: return 32'(cnt_a);
      S_RD1B: return rd1_b;
      S_RD2B: return rd2_b;
      S_CNTC: return 32'(cnt_c);
      S_RD1C: return rd1_c;
      S_B1C:  return 32'(b1_c);
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  // Monitor: outputs are combinational, so every expectation queued for the
  // current cycle is checked at the falling edge.
  always @(negedge Clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = q.pop_front();
      a = actual(e.sel);
      total++;
      if (a !== e.exp) begin
        bad++;
        $display("FAIL %s: got %0h expected %0h", e.name, a, e.exp);
      end
    end
  end

  task automatic expect_v(input string n, input sel_e s, input logic [31:0] v);
    exp_t e;
    e.name = n; e.sel = s; e.exp = v;
    q.push_back(e);
  endtask

  // Advance to just after the next rising edge and return all controls to idle.
  task automatic step();
    @(posedge Clk);
    #1;
    Reset = 1'b0; RegWrite = 1'b0; IssueEnable = 1'b0;
    WR = '0; WD = '0; IR = '0;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d);
    RegWrite = 1'b1; WR = r; WD = d;
  endtask

  initial begin
    Reset = 1'b1; RegWrite = 1'b0; IssueEnable = 1'b0;
    RR1 = '0; RR2 = '0; WR = '0; WD = '0; IR = '0;
    @(posedge Clk);
    #1;

    // Post-reset sweep of every address on both ports.
    for (int i = 0; i < 32; i++) begin
      step();
      RR1 = 5'(i); RR2 = 5'(31 - i);
      expect_v("rst_rd1", S_RD1A, 32'd0);
      expect_v("rst_rd2", S_RD2A, 32'd0);
      expect_v("rst_busy1", S_B1A, 32'd0);
      expect_v("rst_busy2", S_B2A, 32'd0);
      expect_v("rst_dbg", S_DBGA, 32'd0);
      expect_v("rst_cnt", S_CNTA, 32'd0);
    end

    // Basic write / debug tap / write count.
    step(); RR1 = 5'd0; wr(5'd16, 32'd2467);
    step(); RR1 = 5'd16;
    expect_v("r16_rd1", S_RD1A, 32'd2467);
    expect_v("r16_dbg", S_DBGA, 32'd2467);
    expect_v("r16_cnt", S_CNTA, 32'd1);

    // Writes to r0 are dropped, never bypassed and never counted.
    step(); RR1 = 5'd0; wr(5'd0, 32'hDEAD_BEEF);
    expect_v("r0_bypass", S_RD1A, 32'd0);
    step(); RR1 = 5'd0;
    expect_v("r0_rd", S_RD1A, 32'd0);
    expect_v("r0_cnt", S_CNTA, 32'd1);

    // Same-cycle bypass vs. stored-value builds.
    step(); RR1 = 5'd5; RR2 = 5'd5; wr(5'd5, 32'h55);
    expect_v("byp_rd1", S_RD1A, 32'h55);
    expect_v("byp_rd2", S_RD2A, 32'h55);
    expect_v("nobyp_rd1", S_RD1B, 32'h0);
    expect_v("nobyp_rd2", S_RD2B, 32'h0);
    step(); RR1 = 5'd5; RR2 = 5'd5;
    expect_v("nobyp_rd1_next", S_RD1B, 32'h55);
    expect_v("nobyp_rd2_next", S_RD2B, 32'h55);
    expect_v("byp_cnt", S_CNTA, 32'd2);

    // Issue r7, observe busy, then write it back.
    step(); IssueEnable = 1'b1; IR = 5'd7; RR2 = 5'd0;
    step(); RR2 = 5'd7;
    expect_v("iss_busy2", S_B2A, 32'd1);
    step(); RR2 = 5'd7; wr(5'd7, 32'd9);
    expect_v("wb_busy2_byp", S_B2A, 32'd0);
    expect_v("wb_rd2_byp", S_RD2A, 32'd9);
    step(); RR2 = 5'd7;
    expect_v("wb_busy2_after", S_B2A, 32'd0);
    expect_v("wb_rd2_after", S_RD2A, 32'd9);

    // Issue and write to the same register: data lands, pending stays set.
    step(); IssueEnable = 1'b1; IR = 5'd3; wr(5'd3, 32'd4); RR1 = 5'd0; RR2 = 5'd0;
    step(); RR1 = 5'd3;
    expect_v("same_rd1", S_RD1A, 32'd4);
    expect_v("same_busy1", S_B1A, 32'd1);

    // Issue and write to different registers: both take effect.
    step(); IssueEnable = 1'b1; IR = 5'd8; wr(5'd9, 32'h99); RR1 = 5'd0;
    step(); RR1 = 5'd8; RR2 = 5'd9;
    expect_v("diff_busy1", S_B1A, 32'd1);
    expect_v("diff_busy2", S_B2A, 32'd0);
    expect_v("diff_rd2", S_RD2A, 32'h99);
    expect_v("diff_cnt", S_CNTA, 32'd5);
    expect_v("c_cnt5", S_CNTC, 32'd5);

    // Drive the 3-bit counter to saturation (nine accepted writes in total).
    for (int i = 0; i < 4; i++) begin
      step(); RR1 = 5'd0; RR2 = 5'd0; wr(5'(10 + i), 32'(i));
    end
    step();
    expect_v("c_cnt_sat", S_CNTC, 32'd7);
    expect_v("a_cnt9", S_CNTA, 32'd9);

    // r4 = 1 (one more write past saturation), then mark r4 pending.
    step(); wr(5'd4, 32'd1);
    step(); IssueEnable = 1'b1; IR = 5'd4;
    expect_v("c_cnt_hold", S_CNTC, 32'd7);
    step(); RR1 = 5'd4;
    expect_v("pre_rst_rd1", S_RD1C, 32'd1);
    expect_v("pre_rst_busy1", S_B1C, 32'd1);

    // Reset overrides a simultaneous write and issue.
    step(); Reset = 1'b1; wr(5'd4, 32'h77); IssueEnable = 1'b1; IR = 5'd4; RR1 = 5'd4;
    step(); RR1 = 5'd4; RR2 = 5'd16;
    expect_v("post_rst_rd1", S_RD1A, 32'd0);
    expect_v("post_rst_busy1", S_B1A, 32'd0);
    expect_v("post_rst_cnt", S_CNTA, 32'd0);
    expect_v("post_rst_c_cnt", S_CNTC, 32'd0);
    expect_v("post_rst_c_rd1", S_RD1C, 32'd0);
    expect_v("post_rst_c_busy1", S_B1C, 32'd0);
    expect_v("post_rst_rd2", S_RD2A, 32'd0);
    expect_v("post_rst_dbg", S_DBGA, 32'd0);

    @(negedge Clk);
    @(negedge Clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
